// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of scoreboard, writeback-request and register-file write-port signals
// exchanged between the pipeline and regfile_wb_scheduler.
interface regfile_wb_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  // Issue-stage reservation and hazard queries
  logic                  alloc_valid;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  alloc_busy;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;
  logic                  rs1_busy;
  logic                  rs2_busy;

  // Writeback requesters: 0 = ALU, 1 = load/memory
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;

  // Register-file write port and status
  logic                  reg_write;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  wb_unalloc_err;
  logic                  idle;

  modport master (
    output alloc_valid, alloc_addr, rs1_addr, rs2_addr,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  alloc_busy, rs1_busy, rs2_busy, req0_ready, req1_ready,
    input  reg_write, write_addr, write_data, wb_unalloc_err, idle
  );

  modport slave (
    input  alloc_valid, alloc_addr, rs1_addr, rs2_addr,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output alloc_busy, rs1_busy, rs2_busy, req0_ready, req1_ready,
    output reg_write, write_addr, write_data, wb_unalloc_err, idle
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the single register-file write port, with a registered
// write stage and a busy-bit scoreboard for RAW/WAW hazard stalls.
module regfile_wb_scheduler #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_scheduler_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [NumRegs-1:0]    busy_q, busy_d;
  logic                  rr_q, rr_d;
  logic                  reg_write_q, reg_write_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  err_q, err_d;

  logic                  grant0, grant1, xfer;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_nonzero;

  // rr_q selects the winner only when both requesters are valid
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || rr_q);
    xfer   = grant0 || grant1;
    wb_addr = grant1 ? bus.req1_addr : bus.req0_addr;
    wb_data = grant1 ? bus.req1_data : bus.req0_data;
    wb_nonzero = xfer && (wb_addr != '0);
  end

  always_comb begin
    rr_d         = rr_q;
    busy_d       = busy_q;
    err_d        = err_q;
    reg_write_d  = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    if (grant0) begin
      rr_d = 1'b1;
    end else if (grant1) begin
      rr_d = 1'b0;
    end

    if (wb_nonzero) begin
      reg_write_d  = 1'b1;
      write_addr_d = wb_addr;
      write_data_d = wb_data;
      busy_d[wb_addr] = 1'b0;
      if (!busy_q[wb_addr]) begin
        err_d = 1'b1;
      end
    end

    // Set after clear so a same-cycle reallocation keeps the new producer outstanding
    if (bus.alloc_valid && (bus.alloc_addr != '0)) begin
      busy_d[bus.alloc_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      rr_q         <= 1'b0;
      reg_write_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      err_q        <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      rr_q         <= rr_d;
      reg_write_q  <= reg_write_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      err_q        <= err_d;
    end
  end

  // Queries see registered state only; busy_q[0] is held at zero
  always_comb begin
    bus.alloc_busy     = busy_q[bus.alloc_addr];
    bus.rs1_busy       = busy_q[bus.rs1_addr];
    bus.rs2_busy       = busy_q[bus.rs2_addr];
    bus.req0_ready     = grant0;
    bus.req1_ready     = grant1;
    bus.reg_write      = reg_write_q;
    bus.write_addr     = write_addr_q;
    bus.write_data     = write_data_q;
    bus.wb_unalloc_err = err_q;
    bus.idle           = (busy_q == '0) && !reg_write_q;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: hand-computed expectations checked with
// immediate assertions.
module tb_regfile_wb_scheduler;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_wb_scheduler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  regfile_wb_scheduler #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    bus.req0_valid  = 1'b0;
    bus.req0_addr   = '0;
    bus.req0_data   = '0;
    bus.req1_valid  = 1'b0;
    bus.req1_addr   = '0;
    bus.req1_data   = '0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    clear_inputs();

    // Reset state
    #12;
    chk("rst_reg_write", bus.reg_write, 0);
    chk("rst_write_addr", bus.write_addr, 0);
    chk("rst_write_data", bus.write_data, 0);
    chk("rst_err", bus.wb_unalloc_err, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_readies", {bus.req0_ready, bus.req1_ready}, 0);
    rst = 1'b1;

    // Alloc x5, query, then req0 writeback
    tick();
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd5;
    bus.rs1_addr    = 5'd5;
    #1;
    chk("no_bypass_rs1", bus.rs1_busy, 0);
    tick();
    clear_inputs();
    bus.alloc_addr = 5'd5;
    #1;
    chk("x5_rs1_busy", bus.rs1_busy, 1);
    chk("x5_alloc_busy", bus.alloc_busy, 1);
    chk("x5_not_idle", bus.idle, 0);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd5;
    bus.req0_data  = 32'hDEADBEEF;
    #1;
    chk("x5_req0_ready", bus.req0_ready, 1);
    chk("x5_req1_ready", bus.req1_ready, 0);
    tick();
    clear_inputs();
    #1;
    chk("x5_reg_write", bus.reg_write, 1);
    chk("x5_write_addr", bus.write_addr, 5);
    chk("x5_write_data", bus.write_data, 32'hDEADBEEF);
    chk("x5_rs1_cleared", bus.rs1_busy, 0);
    chk("x5_idle_during_write", bus.idle, 0);
    tick();
    chk("x5_reg_write_off", bus.reg_write, 0);
    chk("x5_idle", bus.idle, 1);
    chk("x5_addr_hold", bus.write_addr, 5);
    chk("x5_err", bus.wb_unalloc_err, 0);

    // req1 writeback to x0: accepted, no write, no error; rr_ptr returns to req0
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd0;
    bus.req1_data  = 32'hFFFFFFFF;
    #1;
    chk("x0_req1_ready", bus.req1_ready, 1);
    chk("x0_req0_ready", bus.req0_ready, 0);
    tick();
    clear_inputs();
    #1;
    chk("x0_no_write", bus.reg_write, 0);
    chk("x0_data_hold", bus.write_data, 32'hDEADBEEF);
    chk("x0_err", bus.wb_unalloc_err, 0);
    chk("x0_idle", bus.idle, 1);

    // Alloc x3, x4 then both requesters valid
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd3;
    tick();
    bus.alloc_addr  = 5'd4;
    tick();
    clear_inputs();
    bus.rs1_addr   = 5'd3;
    bus.rs2_addr   = 5'd4;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd3;
    bus.req0_data  = 32'h11;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd4;
    bus.req1_data  = 32'h22;
    #1;
    chk("rr_both_busy", {bus.rs1_busy, bus.rs2_busy}, 2'b11);
    chk("rr_c1_readies", {bus.req0_ready, bus.req1_ready}, 2'b10);
    tick();
    chk("rr_c2_readies", {bus.req0_ready, bus.req1_ready}, 2'b01);
    chk("rr_c2_write", {bus.reg_write, bus.write_addr}, {1'b1, 5'd3});
    chk("rr_c2_data", bus.write_data, 32'h11);
    chk("rr_c2_busy", {bus.rs1_busy, bus.rs2_busy}, 2'b01);
    tick();
    clear_inputs();
    #1;
    chk("rr_c3_write", {bus.reg_write, bus.write_addr}, {1'b1, 5'd4});
    chk("rr_c3_data", bus.write_data, 32'h22);
    chk("rr_c3_busy", {bus.rs1_busy, bus.rs2_busy}, 2'b00);
    chk("rr_c3_err", bus.wb_unalloc_err, 0);

    // x7 allocated, then re-alloc and writeback in the same cycle: set wins
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd7;
    tick();
    bus.rs1_addr   = 5'd7;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd7;
    bus.req0_data  = 32'h77;
    #1;
    chk("x7_req0_ready", bus.req0_ready, 1);
    tick();
    clear_inputs();
    #1;
    chk("x7_write", {bus.reg_write, bus.write_addr}, {1'b1, 5'd7});
    chk("x7_still_busy", bus.rs1_busy, 1);
    chk("x7_err", bus.wb_unalloc_err, 0);

    // Writeback to non-allocated x9 raises the sticky error
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd9;
    bus.req1_data  = 32'h99;
    #1;
    chk("x9_req1_ready", bus.req1_ready, 1);
    tick();
    clear_inputs();
    #1;
    chk("x9_write", {bus.reg_write, bus.write_addr}, {1'b1, 5'd9});
    chk("x9_data", bus.write_data, 32'h99);
    chk("x9_err", bus.wb_unalloc_err, 1);
    tick();
    tick();
    chk("x9_err_sticky", bus.wb_unalloc_err, 1);

    // Alloc x10, x11; req0 writeback leaves rr_ptr at req1; reset mid-cycle
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd10;
    tick();
    bus.alloc_addr  = 5'd11;
    tick();
    clear_inputs();
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd10;
    bus.req0_data  = 32'hA0;
    tick();
    clear_inputs();
    bus.rs1_addr = 5'd11;
    #1;
    chk("pre_rst_write", bus.reg_write, 1);
    chk("pre_rst_busy", bus.rs1_busy, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_reg_write", bus.reg_write, 0);
    chk("arst_busy", bus.rs1_busy, 0);
    chk("arst_err", bus.wb_unalloc_err, 0);
    chk("arst_write_addr", bus.write_addr, 0);
    chk("arst_idle", bus.idle, 1);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_idle", bus.idle, 1);
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 5'd12;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 5'd13;
    #1;
    chk("post_rst_rr", {bus.req0_ready, bus.req1_ready}, 2'b10);
    tick();
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the single register-file write port between two writeback requesters: req0 (ALU result) and req1 (load/memory result).
- Uses round-robin arbitration and a registered write-port drive.
- Keeps a busy-bit scoreboard of destination registers with outstanding results, so the issue stage can stall on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file. Its write-port outputs connect directly to the register file's reg_write, write_addr and write_data.

Parameters:
- DATA_WIDTH, 32, width of write data.
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers, register 0 hardwired zero.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low (asserted at 0).
- alloc_valid  input  1  issue stage reserves a destination register this cycle.
- alloc_addr  input  ADDR_WIDTH  destination register being reserved.
- alloc_busy  output  1  combinational: busy[alloc_addr]; issue stage stalls on WAW.
- rs1_addr  input  ADDR_WIDTH  source register 1 query.
- rs2_addr  input  ADDR_WIDTH  source register 2 query.
- rs1_busy  output  1  combinational: busy[rs1_addr]; 0 for address 0.
- rs2_busy  output  1  combinational: busy[rs2_addr]; 0 for address 0.
- req0_valid / req1_valid  input  1  writeback request valid.
- req0_addr / req1_addr  input  ADDR_WIDTH  writeback destination.
- req0_data / req1_data  input  DATA_WIDTH  writeback value.
- req0_ready / req1_ready  output  1  grant; transfer occurs when valid && ready.
- reg_write  output  1  register-file write enable (registered).
- write_addr  output  ADDR_WIDTH  register-file write address (registered).
- write_data  output  DATA_WIDTH  register-file write data (registered).
- wb_unalloc_err  output  1  sticky: a writeback hit a non-busy register.
- idle  output  1  no busy bits set and reg_write low.

Behaviour:
- Reset (rst=0, asynchronous):
  - busy all 0, rr_ptr=0, reg_write=0, write_addr=0, write_data=0, wb_unalloc_err=0.
  - Outputs drop immediately, including mid-transfer.
  - An in-flight registered write is discarded.
- Arbitration (combinational, at most one grant per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester selected by rr_ptr (0 means req0).
  - Neither valid: no grant, both readies low.
  - readyN is high only for the granted requester and never depends on the other requester's ready.
- rr_ptr update: on each accepted transfer, rr_ptr is set to the index of the non-granted requester. It is unchanged when no transfer occurs.
- Write-port stage (1-cycle latency):
  - At the posedge of an accepted transfer with addr != 0: reg_write=1, write_addr/write_data latch the request.
  - Otherwise reg_write=0; write_addr/write_data hold their last values.
  - The register file commits on the following negedge.
- Address-0 writeback:
  - Accepted (handshake completes), but reg_write stays 0.
  - No scoreboard change and no error.
- Scoreboard, busy[1..2**ADDR_WIDTH-1], busy[0] constant 0:
  - alloc_valid with alloc_addr != 0 sets busy[alloc_addr] at posedge.
  - An accepted writeback with addr != 0 clears busy[addr] at the same posedge that launches reg_write.
  - In the cycle after a writeback is accepted, a consumer sees busy=0 and reads the new value from the register file after the negedge commit.
- Simultaneous alloc and writeback-clear to the same address: set wins, and the new producer stays outstanding.
- Alloc to an already-busy register: bit stays set. Preventing this is the issue stage's responsibility via alloc_busy; no error is raised.
- Writeback to a register with busy=0 (addr != 0):
  - Write still performed.
  - wb_unalloc_err set and held until reset.
- rs1_busy, rs2_busy and alloc_busy reflect registered state only; there is no same-cycle bypass of alloc or clear.
- idle = (busy == 0) && !reg_write.

Test Plan:
- Reset release, then alloc x5 → rs1_addr=5 gives rs1_busy=1. req0 valid (addr 5, data 0xDEADBEEF) → req0_ready=1. Next cycle: reg_write=1, write_addr=5, write_data=0xDEADBEEF, rs1_busy=0. Following cycle: reg_write=0, idle=1.
- Alloc x3 and x4. Both requesters valid every cycle (req0 addr 3, data 0x11; req1 addr 4, data 0x22) → grants alternate req0, req1. reg_write writes x3 then x4 on consecutive cycles. No cycle has both readies high.
- Same cycle: alloc x7 and accepted writeback to x7 → busy[7] stays 1; reg_write=1 next cycle with write_addr=7.
- req1 writeback to x0 with data 0xFFFFFFFF → req1_ready=1, reg_write stays 0, wb_unalloc_err=0. Then writeback to non-allocated x9 → reg_write=1, wb_unalloc_err=1 and remains 1 until reset.
- Alloc x10, x11. Drive rst=0 mid-cycle while reg_write=1 → reg_write, busy and rr_ptr clear immediately, without a clock edge. After release: idle=1, and with both requesters valid, req0 is granted first.
